// File: rtl/tick_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tick_sched_pkg                                                  |
// | Purpose  : Shared definitions for the tick scheduler: channel state        |
// |            encoding, pending-config record width and field layout.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package tick_sched_pkg;

  // Channel run state. OFF holds counter, tick and toggle at zero.
  typedef enum logic [0:0] {
    ST_OFF = 1'b0,
    ST_RUN = 1'b1
  } ch_state_e;

  // Pending record layout, LSB first: {ch, period, en}
  localparam int CFG_EN_BIT     = 0;
  localparam int CFG_PERIOD_LSB = 1;

  function automatic int cfg_w(input int nch, input int cnt_w);
    return $clog2(nch) + cnt_w + 1;
  endfunction

  function automatic int cfg_ch_lsb(input int cnt_w);
    return cnt_w + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/base_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : base_tick_gen                                                   |
// | Purpose  : Free-running prescaler counting 0..PRESCALE-1; flags the last   |
// |            count as the shared base tick. Never reloaded by configuration. |
// | Ports    : clk_i       system clock                                         |
// |            rst_ni      asynchronous active-low reset                        |
// |            base_tick_o combinational, high while count == PRESCALE-1       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module base_tick_gen #(
  parameter int PRESCALE = 100,
  parameter int PRE_W    = 26
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic base_tick_o
);

  localparam logic [PRE_W-1:0] C_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_cnt_q;
  logic [PRE_W-1:0] pre_cnt_d;

  assign base_tick_o = (pre_cnt_q == C_LAST);

  always_comb begin
    pre_cnt_d = pre_cnt_q + PRE_W'(1);
    if (base_tick_o) begin
      pre_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tick_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tick_scheduler                                                  |
// | Purpose  : NCH channels sharing one prescaler; each produces a 1-cycle     |
// |            tick enable and a 50% toggle at a runtime-programmed period.    |
// |            Config arrives over valid/ready, is held in a 1-entry pending   |
// |            register and applied on the next base tick.                     |
// | Ports    : clk_i, rst_ni (async active-low)                                |
// |            cfg_valid_i / cfg_ready_o  config handshake                      |
// |            cfg_ch_i, cfg_period_i, cfg_en_i  config payload                 |
// |            tick_o[NCH]   1-cycle pulse every PRESCALE*period cycles         |
// |            toggle_o[NCH] inverts on every tick                              |
// |            busy_o        config accepted but not yet applied                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int PRESCALE = 100,
  parameter int PRE_W    = 26,
  parameter int CNT_W    = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cfg_valid_i,
  output logic                     cfg_ready_o,
  input  logic [$clog2(NCH)-1:0]   cfg_ch_i,
  input  logic [CNT_W-1:0]         cfg_period_i,
  input  logic                     cfg_en_i,
  output logic [NCH-1:0]           tick_o,
  output logic [NCH-1:0]           toggle_o,
  output logic                     busy_o
);

  localparam int CH_W   = $clog2(NCH);
  localparam int CFG_W  = cfg_w(NCH, CNT_W);
  localparam int CH_LSB = cfg_ch_lsb(CNT_W);

  logic base_tick;

  base_tick_gen #(
    .PRESCALE (PRESCALE),
    .PRE_W    (PRE_W)
  ) u_base_tick_gen (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .base_tick_o (base_tick)
  );

  // ---------------------------------------------------------------- config
  logic             busy_q, busy_d;
  logic [CFG_W-1:0] pend_q, pend_d;
  logic             accept;
  logic             apply;
  logic [CH_W-1:0]  pend_ch;
  logic [CNT_W-1:0] pend_period;
  logic             pend_en;

  assign accept = cfg_valid_i & ~busy_q;
  // busy_q is still 0 on the accept edge, so a base tick coinciding with the
  // accept is skipped and the record applies on the following base tick.
  assign apply  = busy_q & base_tick;

  assign pend_ch     = pend_q[CFG_W-1:CH_LSB];
  assign pend_period = pend_q[CH_LSB-1:CFG_PERIOD_LSB];
  assign pend_en     = pend_q[CFG_EN_BIT];

  assign cfg_ready_o = ~busy_q;
  assign busy_o      = busy_q;

  always_comb begin
    pend_d = pend_q;
    busy_d = busy_q;
    if (accept) begin
      pend_d = {cfg_ch_i, cfg_period_i, cfg_en_i};
      busy_d = 1'b1;
    end else if (apply) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
      busy_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      busy_q <= busy_d;
    end
  end

  // -------------------------------------------------------------- channels
  // Channel indices >= NCH never match any hit, so such records are dropped
  // while busy still clears on the apply edge.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             tog_q, tog_d;
    logic             hit;

    assign hit = apply & (pend_ch == CH_W'(i));

    always_comb begin
      state_d  = state_q;
      period_d = period_q;
      cnt_d    = cnt_q;
      tick_d   = 1'b0;
      tog_d    = tog_q;
      // Apply takes priority over an expiry on the same edge: the phase
      // restarts and that edge produces no tick.
      if (hit) begin
        period_d = pend_period;
        state_d  = (pend_en && (pend_period != '0)) ? ST_RUN : ST_OFF;
        cnt_d    = '0;
        tog_d    = 1'b0;
      end else if ((state_q == ST_RUN) && base_tick) begin
        if (cnt_q == period_q - CNT_W'(1)) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          tog_d  = ~tog_q;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q  <= ST_OFF;
        period_q <= '0;
        cnt_q    <= '0;
        tick_q   <= 1'b0;
        tog_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        period_q <= period_d;
        cnt_q    <= cnt_d;
        tick_q   <= tick_d;
        tog_q    <= tog_d;
      end
    end

    assign tick_o[i]   = tick_q;
    assign toggle_o[i] = tog_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_tick_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_tick_scheduler                                               |
// | Purpose  : Self-checking bench. DUT A (NCH=4) and DUT B (NCH=3, so channel |
// |            index 3 is out of range) share one stimulus. An absolute-time  |
// |            model predicts every output each cycle; directed phases pin    |
// |            hand-computed periods and latencies, then random traffic runs. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_tick_scheduler;

  localparam int NCH      = 4;
  localparam int NCH_B    = 3;
  localparam int PRESCALE = 4;
  localparam int PRE_W    = 3;
  localparam int CNT_W    = 8;
  localparam int CH_W     = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CH_W-1:0]  cfg_ch = '0;
  logic [CNT_W-1:0] cfg_period = '0;
  logic             cfg_en = 1'b0;

  logic             ready_a, busy_a, ready_b, busy_b;
  logic [NCH-1:0]   tick_a, tog_a;
  logic [NCH_B-1:0] tick_b, tog_b;

  always #5 clk = ~clk;

  tick_scheduler #(.NCH(NCH), .PRESCALE(PRESCALE), .PRE_W(PRE_W), .CNT_W(CNT_W)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .cfg_valid_i(cfg_valid), .cfg_ready_o(ready_a),
    .cfg_ch_i(cfg_ch), .cfg_period_i(cfg_period), .cfg_en_i(cfg_en),
    .tick_o(tick_a), .toggle_o(tog_a), .busy_o(busy_a)
  );

  tick_scheduler #(.NCH(NCH_B), .PRESCALE(PRESCALE), .PRE_W(PRE_W), .CNT_W(CNT_W)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .cfg_valid_i(cfg_valid), .cfg_ready_o(ready_b),
    .cfg_ch_i(cfg_ch), .cfg_period_i(cfg_period), .cfg_en_i(cfg_en),
    .tick_o(tick_b), .toggle_o(tog_b), .busy_o(busy_b)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // ------------------------------------------------------------ model
  // Edge k (counted from reset release) is a base tick when k%PRESCALE is
  // PRESCALE-1. A channel applied on edge k next ticks on edge
  // k+PRESCALE*period and every PRESCALE*period edges after that.
  int             m_k;
  bit             m_pend;
  int             m_pch, m_pper;
  bit             m_pen;
  bit             m_run [NCH];
  int             m_per [NCH];
  int             m_next[NCH];
  logic [NCH-1:0] m_tick, m_tog;
  bit             m_bt, m_ap;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k = 0; m_pend = 0; m_pch = 0; m_pper = 0; m_pen = 0;
      m_tick = '0; m_tog = '0;
      for (int c = 0; c < NCH; c++) begin
        m_run[c] = 0; m_per[c] = 0; m_next[c] = 0;
      end
    end else begin
      m_bt = ((m_k % PRESCALE) == PRESCALE - 1);
      m_ap = m_pend && m_bt;
      for (int c = 0; c < NCH; c++) begin
        m_tick[c] = 1'b0;
        if (m_ap && m_pch == c) begin
          m_run[c]  = m_pen && (m_pper != 0);
          m_per[c]  = m_pper;
          m_next[c] = m_k + PRESCALE * m_pper;
          m_tog[c]  = 1'b0;
        end else if (m_run[c] && m_k == m_next[c]) begin
          m_tick[c] = 1'b1;
          m_tog[c]  = ~m_tog[c];
          m_next[c] = m_next[c] + PRESCALE * m_per[c];
        end
      end
      if (m_ap) begin
        m_pend = 0;
      end else if (!m_pend && cfg_valid) begin
        m_pend = 1;
        m_pch  = int'(cfg_ch);
        m_pper = int'(cfg_period);
        m_pen  = cfg_en;
      end
      m_k++;
    end
  end

  // ------------------------------------------------------------ compare
  always @(negedge clk) begin
    check("a_tick",   tick_a,  m_tick);
    check("a_toggle", tog_a,   m_tog);
    check("a_busy",   busy_a,  m_pend);
    check("a_ready",  ready_a, !m_pend);
    check("b_tick",   tick_b,  m_tick[NCH_B-1:0]);
    check("b_toggle", tog_b,   m_tog[NCH_B-1:0]);
    check("b_busy",   busy_b,  m_pend);
    check("b_ready",  ready_b, !m_pend);
  end

  // ------------------------------------------------------------ helpers
  // All helpers are entered and left just after a falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic write_cfg(input int ch, input int per, input bit en, output int waited);
    bit acc;
    waited = 0;
    cfg_valid  = 1'b1;
    cfg_ch     = CH_W'(ch);
    cfg_period = CNT_W'(per);
    cfg_en     = en;
    do begin
      acc = ready_a;
      step(1);
      if (!acc) waited++;
    end while (!acc && waited < 100);
    cfg_valid = 1'b0;
    check("write_accepted", acc, 1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy_a && n < 50) begin
      step(1);
      n++;
    end
    check("busy_clears", busy_a, 0);
  endtask

  task automatic wait_tick(input int c, output int t);
    int g = 0;
    do begin
      step(1);
      g++;
    end while (!tick_a[c] && g < 200);
    check("tick_seen", tick_a[c], 1);
    t = cyc;
  endtask

  // ------------------------------------------------------------ stimulus
  int w, n, t1, t2, ta, te;
  logic [NCH-1:0] seen;

  initial begin
    // 1. reset held with clock running
    repeat (3) @(negedge clk);
    check("rst_tick",   tick_a,  0);
    check("rst_toggle", tog_a,   0);
    check("rst_busy",   busy_a,  0);
    check("rst_ready",  ready_a, 1);
    rst_n = 1'b1;
    seen = '0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      seen = seen | tick_a;
    end
    check("idle_no_tick", seen, 0);

    // 2. ch0 period 3: apply within 1..4 edges, tick every 12, toggle period 24
    write_cfg(0, 3, 1'b1, w);
    wait_idle(n);
    check("apply_latency_1to4", (n >= 1 && n <= PRESCALE), 1);
    ta = cyc;
    wait_tick(0, t1);
    check("ch0_first_tick_12", t1 - ta, 12);
    check("ch0_toggle_high", tog_a[0], 1);
    wait_tick(0, t2);
    check("ch0_gap_12", t2 - t1, 12);
    check("ch0_toggle_low", tog_a[0], 0);

    // 3. ch1 period 1, ch2 period 5, ch0 undisturbed
    write_cfg(1, 1, 1'b1, w);
    write_cfg(2, 5, 1'b1, w);
    wait_idle(n);
    wait_tick(1, t1); wait_tick(1, t2);
    check("ch1_gap_4", t2 - t1, 4);
    wait_tick(2, t1); wait_tick(2, t2);
    check("ch2_gap_20", t2 - t1, 20);
    wait_tick(0, t1); wait_tick(0, t2);
    check("ch0_still_12", t2 - t1, 12);

    // 4. second write held while busy; both apply in order (last wins)
    write_cfg(3, 2, 1'b1, w);
    write_cfg(3, 4, 1'b1, w);
    check("second_write_waited", (w >= 1), 1);
    wait_idle(n);
    wait_tick(3, t1); wait_tick(3, t2);
    check("ch3_gap_16", t2 - t1, 16);

    // 5. ch0 rewrite applied on its own expiry edge
    wait_tick(0, t1);
    step(9);
    write_cfg(0, 2, 1'b1, w);
    check("rewrite_accept_edge", cyc, t1 + 10);
    step(2);
    te = cyc;
    check("apply_wins_no_tick", tick_a[0], 0);
    check("apply_wins_toggle0", tog_a[0], 0);
    check("apply_done", busy_a, 0);
    wait_tick(0, t2);
    check("ch0_after_rewrite_8", t2 - te, 8);

    // 6. period 0 turns ch1 off; ch3 write is out of range for DUT B
    write_cfg(1, 0, 1'b1, w);
    wait_idle(n);
    check("ch1_off_toggle", tog_a[1], 0);
    seen = '0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      seen = seen | tick_a;
    end
    check("ch1_off_no_tick", seen[1], 0);
    write_cfg(3, 1, 1'b1, w);
    n = 0;
    while (busy_b && n < 50) begin
      step(1);
      n++;
    end
    check("b_discard_busy_clears", (n >= 1 && n <= PRESCALE), 1);

    // random traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      cfg_valid  = ($urandom_range(0, 2) == 0);
      cfg_ch     = CH_W'($urandom);
      cfg_period = CNT_W'($urandom_range(0, 7));
      cfg_en     = ($urandom_range(0, 4) != 0);
      step(1);
    end
    cfg_valid = 1'b0;
    step(1);
    wait_idle(n);

    // 7. asynchronous reset while a tick is high
    write_cfg(0, 1, 1'b1, w);
    wait_idle(n);
    wait_tick(0, t1);
    check("pre_reset_tick", tick_a[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tick",   tick_a,  0);
    check("async_rst_toggle", tog_a,   0);
    check("async_rst_busy",   busy_a,  0);
    check("async_rst_ready",  ready_a, 1);
    @(negedge clk);
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
